// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency single-port RAM between IF fetch and
//            MEM load/store, stalling the pipeline until each access ends.
//            Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LATENCY   = 2,
    parameter int MAX_DEFER = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              stall_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int                 C_CNT_W   = $clog2(LATENCY + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAT = C_CNT_W'(LATENCY);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic                store_q, store_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;

    logic                if_first;
    logic                grant_mem;
    logic                grant_if;

    // MEM is the older instruction and wins ties unless IF has been deferred too long
    assign grant_mem = (state_q == S_IDLE) & mem_req_i & ~(if_first & if_req_i);
    assign grant_if  = (state_q == S_IDLE) & if_req_i & ~grant_mem;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int                 C_DEF_W   = $clog2(MAX_DEFER + 1);
    localparam logic [C_DEF_W-1:0] C_DEF_MAX = C_DEF_W'(MAX_DEFER);

    logic [C_DEF_W-1:0] defer_q, defer_d;

    assign if_first = (defer_q == C_DEF_MAX);

    always_comb begin
        defer_d = defer_q;
        if (grant_if) begin
            defer_d = '0;
        end else if (grant_mem && if_req_i && !if_first) begin
            defer_d = defer_q + C_DEF_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end
`else
    assign if_first = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        store_d     = store_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_mem) begin
                    state_d     = S_BUSY_MEM;
                    cnt_d       = C_CNT_LAT;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_we_i;
                    store_d     = mem_we_i;
                    ram_addr_d  = mem_addr_i;
                    ram_wdata_d = mem_wdata_i;
                end else if (grant_if) begin
                    state_d     = S_BUSY_IF;
                    cnt_d       = C_CNT_LAT;
                    ram_en_d    = 1'b1;
                    store_d     = 1'b0;
                    ram_addr_d  = if_addr_i;
                end
            end
            S_BUSY_IF: begin
                if (cnt_q == C_CNT_ONE) begin
                    if_rdata_d = ram_rdata_i;
                    if_ready_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_BUSY_MEM: begin
                if (cnt_q == C_CNT_ONE) begin
                    // A store completes without touching the load-data register
                    if (!store_q) begin
                        mem_rdata_d = ram_rdata_i;
                    end
                    mem_ready_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            store_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            store_q     <= store_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign stall_o     = (if_req_i & ~if_ready_q) | (mem_req_i & ~mem_ready_q);

endmodule
`default_nettype wire
